// File: rtl/execute_md_cycle.sv
// Execute stage with single-cycle ALU/compare and an iterative RV32M/RV64M multiply/divide unit.
// Owns the EX/MEM register; M operations hold the front of the pipeline via o_execute_busy.
module execute_md_cycle #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned FWD_SRC = 2,
  localparam int unsigned SW     = $clog2(FWD_SRC + 1)
) (
  input  logic                    i_execute_clk,
  input  logic                    i_execute_reset_n,
  input  logic [XLEN-1:0]         i_execute_pc,
  input  logic [XLEN-1:0]         i_execute_rs1_data,
  input  logic [XLEN-1:0]         i_execute_rs2_data,
  input  logic [XLEN-1:0]         i_execute_imm_out,
  input  logic [31:0]             i_execute_inst,
  input  logic                    i_execute_insn_vld,
  input  logic                    i_execute_ctrl,
  input  logic                    i_execute_lsu_wren,
  input  logic                    i_execute_rd_wren,
  input  logic [2:0]              i_execute_slt_sl,
  input  logic [1:0]              i_execute_wb_sel,
  input  logic                    i_execute_asel,
  input  logic                    i_execute_bsel,
  input  logic                    i_execute_br_un,
  input  logic [3:0]              i_execute_alu_op,
  input  logic                    i_execute_md_en,
  input  logic [2:0]              i_execute_md_op,
  input  logic                    i_execute_flush,
  input  logic                    i_execute_stall,
  input  logic [SW-1:0]           i_execute_fwd_sel_a,
  input  logic [SW-1:0]           i_execute_fwd_sel_b,
  input  logic [FWD_SRC*XLEN-1:0] i_execute_fwd_data,
  output logic [XLEN-1:0]         o_execute_alu_data,
  output logic [XLEN-1:0]         o_execute_rs2_data_mem,
  output logic [XLEN-1:0]         o_execute_pc_mem,
  output logic [31:0]             o_execute_inst_mem,
  output logic                    o_execute_br_equal_mem,
  output logic                    o_execute_br_less_mem,
  output logic                    o_execute_insn_vld_mem,
  output logic                    o_execute_ctrl,
  output logic                    o_execute_lsu_wren_mem,
  output logic [2:0]              o_execute_slt_sl_mem,
  output logic [1:0]              o_execute_wb_sel_mem,
  output logic                    o_execute_rd_wren_mem,
  output logic [XLEN-1:0]         o_execute_alu_data_decode,
  output logic                    o_execute_busy
);

  localparam int unsigned CW  = $clog2(XLEN);
  localparam logic [31:0] NopInst = 32'h0000_0013;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  localparam logic [2:0] MdMul    = 3'd0;
  localparam logic [2:0] MdMulhsu = 3'd2;
  localparam logic [2:0] MdMulhu  = 3'd3;
  localparam logic [2:0] MdDivu   = 3'd5;
  localparam logic [2:0] MdRemu   = 3'd7;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  md_state_e           r_state, w_state_next;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_op;
  logic                r_neg_q, r_neg_r, r_div_zero, r_ovf;
  logic [XLEN-1:0]     r_mcand, r_hi, r_lo;

  logic [XLEN-1:0]     w_fwd_a, w_fwd_b, w_op_a, w_op_b, w_alu;
  logic [CW-1:0]       w_shamt;
  logic                w_br_equal, w_br_less, w_issue;
  logic                w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag;
  logic [XLEN:0]       w_mul_sum, w_div_shift, w_div_diff;
  logic [XLEN-1:0]     w_hi_step, w_lo_step;
  logic [2*XLEN-1:0]   w_prod_s;
  logic [XLEN-1:0]     w_quot, w_rem, w_md_result;

  always_comb begin
    w_fwd_a = i_execute_rs1_data;
    w_fwd_b = i_execute_rs2_data;
    for (int unsigned k = 1; k <= FWD_SRC; k++) begin
      if (i_execute_fwd_sel_a == SW'(k)) w_fwd_a = i_execute_fwd_data[k*XLEN-1 -: XLEN];
      if (i_execute_fwd_sel_b == SW'(k)) w_fwd_b = i_execute_fwd_data[k*XLEN-1 -: XLEN];
    end
  end

  assign w_op_a  = i_execute_asel ? i_execute_pc : w_fwd_a;
  assign w_op_b  = i_execute_bsel ? i_execute_imm_out : w_fwd_b;
  assign w_shamt = w_op_b[CW-1:0];

  always_comb begin
    case (i_execute_alu_op)
      AluAdd:   w_alu = w_op_a + w_op_b;
      AluSub:   w_alu = w_op_a - w_op_b;
      AluSll:   w_alu = w_op_a << w_shamt;
      AluSlt:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
      AluSltu:  w_alu = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
      AluXor:   w_alu = w_op_a ^ w_op_b;
      AluSrl:   w_alu = w_op_a >> w_shamt;
      AluSra:   w_alu = $signed(w_op_a) >>> w_shamt;
      AluOr:    w_alu = w_op_a | w_op_b;
      AluAnd:   w_alu = w_op_a & w_op_b;
      AluPassB: w_alu = w_op_b;
      default:  w_alu = '0;
    endcase
  end

  assign w_br_equal = (w_fwd_a == w_fwd_b);
  assign w_br_less  = i_execute_br_un ? (w_fwd_a < w_fwd_b) : ($signed(w_fwd_a) < $signed(w_fwd_b));

  // Operands are reduced to magnitudes at issue; the sign is re-applied in DONE.
  assign w_issue    = (r_state == StIdle) & i_execute_md_en & i_execute_insn_vld &
                      ~i_execute_flush & ~i_execute_stall;
  assign w_a_signed = ~((i_execute_md_op == MdMulhu) | (i_execute_md_op == MdDivu) |
                        (i_execute_md_op == MdRemu));
  assign w_b_signed = w_a_signed & (i_execute_md_op != MdMulhsu);
  assign w_a_neg    = w_a_signed & w_fwd_a[XLEN-1];
  assign w_b_neg    = w_b_signed & w_fwd_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -w_fwd_a : w_fwd_a;
  assign w_b_mag    = w_b_neg ? -w_fwd_b : w_fwd_b;

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    w_div_shift = {r_hi, r_lo[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, r_mcand};
    if (!r_op[2]) begin
      {w_hi_step, w_lo_step} = {w_mul_sum, r_lo[XLEN-1:1]};
    end else if (!w_div_diff[XLEN]) begin
      w_hi_step = w_div_diff[XLEN-1:0];
      w_lo_step = {r_lo[XLEN-2:0], 1'b1};
    end else begin
      w_hi_step = w_div_shift[XLEN-1:0];
      w_lo_step = {r_lo[XLEN-2:0], 1'b0};
    end
  end

  // A zero divisor leaves the dividend in the remainder, so only the quotient is overridden.
  always_comb begin
    w_prod_s = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_quot   = r_div_zero ? '1 :
               r_ovf      ? {1'b1, {(XLEN-1){1'b0}}} :
               r_neg_q    ? -r_lo : r_lo;
    w_rem    = r_ovf ? '0 : (r_neg_r ? -r_hi : r_hi);
    if (!r_op[2]) w_md_result = (r_op == MdMul) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    else          w_md_result = r_op[1] ? w_rem : w_quot;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_issue) w_state_next = StBusy;
      StBusy:  if (r_cnt == CW'(XLEN - 1)) w_state_next = StDone;
      StDone:  if (!i_execute_stall) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (i_execute_flush) w_state_next = StIdle;
  end

  always_ff @(posedge i_execute_clk or negedge i_execute_reset_n) begin
    if (!i_execute_reset_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_op       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
      r_mcand    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_cnt      <= '0;
        r_op       <= i_execute_md_op;
        r_neg_q    <= w_a_neg ^ w_b_neg;
        r_neg_r    <= w_a_neg;
        r_div_zero <= (w_fwd_b == '0);
        r_ovf      <= w_b_signed & i_execute_md_op[2] & (w_fwd_b == '1) &
                      (w_fwd_a == {1'b1, {(XLEN-1){1'b0}}});
        r_mcand    <= w_b_mag;
        r_hi       <= '0;
        r_lo       <= w_a_mag;
      end else if (r_state == StBusy) begin
        r_cnt <= r_cnt + CW'(1);
        r_hi  <= w_hi_step;
        r_lo  <= w_lo_step;
      end
    end
  end

  assign o_execute_busy            = w_issue | (r_state == StBusy);
  assign o_execute_alu_data_decode = w_alu;

  logic [XLEN-1:0] w_n_alu, w_n_rs2, w_n_pc;
  logic [31:0]     w_n_inst;
  logic            w_n_br_eq, w_n_br_lt, w_n_vld, w_n_ctrl, w_n_lsu_wren, w_n_rd_wren;
  logic [2:0]      w_n_slt_sl;
  logic [1:0]      w_n_wb_sel;

  always_comb begin
    w_n_alu      = w_alu;
    w_n_rs2      = w_fwd_b;
    w_n_pc       = i_execute_pc;
    w_n_inst     = i_execute_inst;
    w_n_br_eq    = w_br_equal;
    w_n_br_lt    = w_br_less;
    w_n_vld      = i_execute_insn_vld;
    w_n_ctrl     = i_execute_ctrl;
    w_n_lsu_wren = i_execute_lsu_wren;
    w_n_rd_wren  = i_execute_rd_wren;
    w_n_slt_sl   = i_execute_slt_sl;
    w_n_wb_sel   = i_execute_wb_sel;
    if (i_execute_flush || w_issue || (r_state == StBusy)) begin
      w_n_alu      = '0;
      w_n_rs2      = '0;
      w_n_pc       = '0;
      w_n_inst     = NopInst;
      w_n_br_eq    = 1'b0;
      w_n_br_lt    = 1'b0;
      w_n_vld      = 1'b0;
      w_n_ctrl     = i_execute_flush & i_execute_ctrl;
      w_n_lsu_wren = 1'b0;
      w_n_rd_wren  = 1'b0;
      w_n_slt_sl   = '0;
      w_n_wb_sel   = '0;
    end else if (r_state == StDone) begin
      w_n_alu   = w_md_result;
      w_n_br_eq = 1'b0;
      w_n_br_lt = 1'b0;
    end
  end

  // Flush overrides stall; otherwise a stall freezes the whole register.
  always_ff @(posedge i_execute_clk or negedge i_execute_reset_n) begin
    if (!i_execute_reset_n) begin
      o_execute_alu_data     <= '0;
      o_execute_rs2_data_mem <= '0;
      o_execute_pc_mem       <= '0;
      o_execute_inst_mem     <= NopInst;
      o_execute_br_equal_mem <= 1'b0;
      o_execute_br_less_mem  <= 1'b0;
      o_execute_insn_vld_mem <= 1'b0;
      o_execute_ctrl         <= 1'b0;
      o_execute_lsu_wren_mem <= 1'b0;
      o_execute_rd_wren_mem  <= 1'b0;
      o_execute_slt_sl_mem   <= '0;
      o_execute_wb_sel_mem   <= '0;
    end else if (i_execute_flush || !i_execute_stall) begin
      o_execute_alu_data     <= w_n_alu;
      o_execute_rs2_data_mem <= w_n_rs2;
      o_execute_pc_mem       <= w_n_pc;
      o_execute_inst_mem     <= w_n_inst;
      o_execute_br_equal_mem <= w_n_br_eq;
      o_execute_br_less_mem  <= w_n_br_lt;
      o_execute_insn_vld_mem <= w_n_vld;
      o_execute_ctrl         <= w_n_ctrl;
      o_execute_lsu_wren_mem <= w_n_lsu_wren;
      o_execute_rd_wren_mem  <= w_n_rd_wren;
      o_execute_slt_sl_mem   <= w_n_slt_sl;
      o_execute_wb_sel_mem   <= w_n_wb_sel;
    end
  end

endmodule

// File: tb/tb_execute_md_cycle.sv
// Scoreboard bench for execute_md_cycle: ALU ops, M ops, flush, stall across DONE, async reset.
module tb_execute_md_cycle;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned FWD_SRC = 2;
  localparam int unsigned SW      = $clog2(FWD_SRC + 1);
  localparam logic [31:0] NopInst = 32'h0000_0013;
  localparam logic [31:0] Src1    = 32'h0000_0100;
  localparam logic [31:0] Src2    = 32'h0000_0010;

  localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluSlt = 4'd3, AluSltu = 4'd4;
  localparam logic [3:0] AluXor = 4'd5, AluSra = 4'd7;
  localparam logic [2:0] MdMul = 3'd0, MdMulh = 3'd1, MdMulhsu = 3'd2, MdMulhu = 3'd3;
  localparam logic [2:0] MdDiv = 3'd4, MdDivu = 3'd5, MdRem = 3'd6, MdRemu = 3'd7;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n;

  logic [XLEN-1:0] pc, rs1, rs2, imm;
  logic [31:0] inst;
  logic insn_vld, ctrl, lsu_wren, rd_wren, asel, bsel, br_un, md_en, flush, stall;
  logic [2:0] slt_sl, md_op;
  logic [1:0] wb_sel;
  logic [3:0] alu_op;
  logic [SW-1:0] sel_a, sel_b;
  logic [FWD_SRC*XLEN-1:0] fwd_data;

  logic [XLEN-1:0] o_alu, o_rs2, o_pc, o_alu_dec;
  logic [31:0] o_inst;
  logic o_br_eq, o_br_lt, o_vld, o_ctrl, o_lsu_wren, o_rd_wren, o_busy;
  logic [2:0] o_slt_sl;
  logic [1:0] o_wb_sel;

  execute_md_cycle #(.XLEN(XLEN), .FWD_SRC(FWD_SRC)) dut (
    .i_execute_clk(clk), .i_execute_reset_n(rst_n),
    .i_execute_pc(pc), .i_execute_rs1_data(rs1), .i_execute_rs2_data(rs2),
    .i_execute_imm_out(imm), .i_execute_inst(inst), .i_execute_insn_vld(insn_vld),
    .i_execute_ctrl(ctrl), .i_execute_lsu_wren(lsu_wren), .i_execute_rd_wren(rd_wren),
    .i_execute_slt_sl(slt_sl), .i_execute_wb_sel(wb_sel), .i_execute_asel(asel),
    .i_execute_bsel(bsel), .i_execute_br_un(br_un), .i_execute_alu_op(alu_op),
    .i_execute_md_en(md_en), .i_execute_md_op(md_op), .i_execute_flush(flush),
    .i_execute_stall(stall), .i_execute_fwd_sel_a(sel_a), .i_execute_fwd_sel_b(sel_b),
    .i_execute_fwd_data(fwd_data),
    .o_execute_alu_data(o_alu), .o_execute_rs2_data_mem(o_rs2), .o_execute_pc_mem(o_pc),
    .o_execute_inst_mem(o_inst), .o_execute_br_equal_mem(o_br_eq),
    .o_execute_br_less_mem(o_br_lt), .o_execute_insn_vld_mem(o_vld), .o_execute_ctrl(o_ctrl),
    .o_execute_lsu_wren_mem(o_lsu_wren), .o_execute_slt_sl_mem(o_slt_sl),
    .o_execute_wb_sel_mem(o_wb_sel), .o_execute_rd_wren_mem(o_rd_wren),
    .o_execute_alu_data_decode(o_alu_dec), .o_execute_busy(o_busy)
  );

  always #5 if (clk_en) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] rs2;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [31:0] cur_pc = 32'h0000_1000;

  always @(negedge clk) begin
    if (rst_n && o_vld) begin
      check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_val("out_pc", o_pc, mon_e.pc);
        check_val("out_data", o_alu, mon_e.data);
        check_val("out_rs2", o_rs2, mon_e.rs2);
        check_val("out_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic go_idle();
    insn_vld = 1'b0; md_en = 1'b0; md_op = '0; alu_op = AluAdd; rd_wren = 1'b0;
    wb_sel = '0; asel = 1'b0; bsel = 1'b0; br_un = 1'b0; sel_a = '0; sel_b = '0;
    flush = 1'b0; stall = 1'b0; ctrl = 1'b0; lsu_wren = 1'b0; slt_sl = '0;
  endtask

  task automatic drive_op(input logic md, input logic [2:0] mop, input logic [3:0] aop,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [SW-1:0] sa, input logic [SW-1:0] sb,
                          input logic bs, input logic [31:0] im);
    pc = cur_pc; cur_pc = cur_pc + 32'd4;
    inst = {cur_pc[19:0], 12'h033};
    insn_vld = 1'b1; md_en = md; md_op = mop; alu_op = aop;
    rs1 = a; rs2 = b; sel_a = sa; sel_b = sb; bsel = bs; imm = im;
    rd_wren = 1'b1; wb_sel = 2'b01;
  endtask

  task automatic send(input logic md, input logic [2:0] mop, input logic [3:0] aop,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [SW-1:0] sa, input logic [SW-1:0] sb,
                      input logic bs, input logic [31:0] im,
                      input logic [31:0] exp_data, input int stall_n);
    int busy_n;
    int c0;
    exp_t e;
    logic [31:0] hold;
    @(posedge clk); #1;
    drive_op(md, mop, aop, a, b, sa, sb, bs, im);
    c0 = cyc;
    #1;
    busy_n = 0;
    while (o_busy && busy_n < 200) begin
      busy_n++;
      if (busy_n == 5) check_val("md_bubble_vld", o_vld, 0);
      @(posedge clk); #2;
    end
    if (md) check_val("md_busy_cycles", busy_n, XLEN + 1);
    else    check_val("alu_busy", busy_n, 0);
    e.pc   = pc;
    e.data = exp_data;
    e.rs2  = (sb == SW'(1)) ? Src1 : (sb == SW'(2)) ? Src2 : b;
    e.due  = c0 + (md ? XLEN + 2 : 1) + stall_n;
    sb_q.push_back(e);
    if (stall_n > 0) begin
      stall = 1'b1;
      hold  = o_alu;
      repeat (stall_n) begin
        @(posedge clk); #1;
        check_val("stall_hold_data", o_alu, hold);
        check_val("stall_hold_vld", o_vld, 0);
      end
      stall = 1'b0;
    end
    @(posedge clk); #1;
    go_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    go_idle();
    pc = '0; rs1 = '0; rs2 = '0; imm = '0; inst = '0;
    fwd_data = {Src2, Src1};
    #12;
    check_val("rst_inst", o_inst, NopInst);
    check_val("rst_alu", o_alu, 0);
    check_val("rst_vld", o_vld, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_pc", o_pc, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ALU path with forwarding
    send(0, MdMul, AluAdd, 32'h0000_DEAD, 32'h5, 2, 0, 0, 0, 32'h15, 0);
    send(0, MdMul, AluSub, 32'h1000, 32'h7, 0, 1, 0, 0, 32'hF00, 0);
    send(0, MdMul, AluXor, 32'hFF00_FF00, 32'h0FF0_0FF0, 3, 3, 0, 0, 32'hF0F0_F0F0, 0);
    send(0, MdMul, AluSltu, 32'h3, 32'h0, 0, 0, 1, 32'h5, 32'h1, 0);
    send(0, MdMul, AluSlt, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 32'h1, 0);
    send(0, MdMul, AluSltu, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 32'h0, 0);
    send(0, MdMul, AluSra, 32'h8000_0000, 32'h4, 0, 0, 0, 0, 32'hF800_0000, 0);

    // Multiply/divide, including corner cases
    send(1, MdMulh, AluAdd, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 32'h4000_0000, 0);
    send(1, MdDiv, AluAdd, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h8000_0000, 0);
    send(1, MdRem, AluAdd, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0, 0);
    send(1, MdDivu, AluAdd, 32'h7, 32'h0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    send(1, MdRemu, AluAdd, 32'h7, 32'h0, 0, 0, 0, 0, 32'h7, 0);
    send(1, MdMul, AluAdd, 32'hFFFF_FFFD, 32'h5, 0, 0, 0, 0, 32'hFFFF_FFF1, 0);
    send(1, MdMulhu, AluAdd, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFE, 0);
    send(1, MdMulhsu, AluAdd, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    send(1, MdDiv, AluAdd, 32'hFFFF_FFF9, 32'h2, 0, 0, 0, 0, 32'hFFFF_FFFD, 0);
    send(1, MdRem, AluAdd, 32'hFFFF_FFF9, 32'h2, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    send(1, MdDiv, AluAdd, 32'hFFFF_FFF9, 32'h0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    send(1, MdRem, AluAdd, 32'hFFFF_FFF9, 32'h0, 0, 0, 0, 0, 32'hFFFF_FFF9, 0);
    send(1, MdDivu, AluAdd, 32'd100, 32'd7, 0, 0, 0, 0, 32'd14, 0);
    send(1, MdRemu, AluAdd, 32'd100, 32'd7, 0, 0, 0, 0, 32'd2, 0);
    send(1, MdMul, AluAdd, 32'h0, 32'h3, 2, 0, 0, 0, 32'h30, 0);

    // Flush during BUSY cycle 10 of a DIVU
    @(posedge clk); #1;
    drive_op(1, MdDivu, AluAdd, 32'd1000, 32'd3, 0, 0, 0, 0);
    #1;
    check_val("flush_issue_busy", o_busy, 1);
    repeat (10) @(posedge clk);
    #1;
    go_idle();
    flush = 1'b1;
    ctrl  = 1'b1;
    #1;
    check_val("flush_busy_pre", o_busy, 1);
    @(posedge clk); #1;
    go_idle();
    #1;
    check_val("flush_busy_post", o_busy, 0);
    check_val("flush_vld", o_vld, 0);
    check_val("flush_inst", o_inst, NopInst);
    check_val("flush_alu", o_alu, 0);
    check_val("flush_ctrl", o_ctrl, 1);
    send(0, MdMul, AluAdd, 32'h20, 32'h22, 0, 0, 0, 0, 32'h42, 0);

    // Stall held across DONE
    send(1, MdMul, AluAdd, 32'd6, 32'd7, 0, 0, 0, 0, 32'd42, 3);

    // Async reset mid-MUL with the clock stopped
    @(posedge clk); #1;
    drive_op(1, MdMul, AluAdd, 32'd6, 32'd7, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    check_val("mid_mul_busy", o_busy, 1);
    go_idle();
    rst_n = 1'b0;
    #1;
    check_val("async_rst_inst", o_inst, NopInst);
    check_val("async_rst_busy", o_busy, 0);
    check_val("async_rst_alu", o_alu, 0);
    check_val("async_rst_vld", o_vld, 0);
    #5;
    rst_n = 1'b1;
    #2;
    clk_en = 1'b1;
    send(0, MdMul, AluAdd, 32'h1, 32'h2, 0, 0, 0, 0, 32'h3, 0);

    repeat (4) @(posedge clk);
    #1;
    check_val("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_md_cycle.md
# execute_md_cycle

Parametrised execute stage with an integrated iterative multiply/divide unit (RV32M/RV64M semantics). It sits between the ID/EX and EX/MEM boundaries and owns the EX/MEM pipeline register. Single-cycle ALU and branch-compare operations pass through in one cycle. MUL/DIV/REM operations run for XLEN+2 cycles and hold the front of the pipeline with `o_execute_busy`. Forwarding is generalised to FWD_SRC bypass sources.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64)
- FWD_SRC, 2, number of bypass sources; select width SW = $clog2(FWD_SRC+1)

Ports:
- i_execute_clk  in  1  clock, rising edge
- i_execute_reset_n  in  1  asynchronous, active-low reset
- i_execute_pc, i_execute_rs1_data, i_execute_rs2_data, i_execute_imm_out  in  XLEN each  PC, register operands, immediate
- i_execute_inst  in  32  instruction word
- i_execute_insn_vld, i_execute_ctrl  in  1 each  instruction valid; control-transfer flag
- i_execute_lsu_wren, i_execute_rd_wren  in  1 each  MEM and WB controls (pass-through)
- i_execute_slt_sl  in  3  MEM control (pass-through)
- i_execute_wb_sel  in  2  WB control (pass-through)
- i_execute_asel, i_execute_bsel, i_execute_br_un  in  1 each  operand A = PC; operand B = imm; unsigned compare
- i_execute_alu_op  in  4  ALU opcode
- i_execute_md_en  in  1  instruction is an M-extension operation
- i_execute_md_op  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- i_execute_flush, i_execute_stall  in  1 each  flush; downstream stall
- i_execute_fwd_sel_a, i_execute_fwd_sel_b  in  SW each  0 = register file, k = bypass source k
- i_execute_fwd_data  in  FWD_SRC*XLEN  bypass data; source k occupies bits [k*XLEN-1 -: XLEN]
- o_execute_alu_data, o_execute_rs2_data_mem, o_execute_pc_mem  out  XLEN each  registered result, store data, PC
- o_execute_inst_mem  out  32  registered instruction
- o_execute_br_equal_mem, o_execute_br_less_mem, o_execute_insn_vld_mem, o_execute_ctrl  out  1 each  registered
- o_execute_lsu_wren_mem, o_execute_slt_sl_mem, o_execute_wb_sel_mem, o_execute_rd_wren_mem  out  1/3/2/1  registered controls
- o_execute_alu_data_decode  out  XLEN  combinational ALU result (early forward)
- o_execute_busy  out  1  M-unit owns the stage; upstream must hold ID/EX

## Operation
- Operand path:
  - fwd_a and fwd_b come from a (FWD_SRC+1):1 mux; sel values above FWD_SRC select the register file.
  - ALU input A = asel ? PC : fwd_a; input B = bsel ? imm : fwd_b.
  - The comparator uses fwd_a and fwd_b directly.
- M-unit FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY on issue = md_en & insn_vld & !flush & !stall. At issue, capture fwd_a and fwd_b magnitudes, result-sign flags and op; clear the counter.
  - BUSY: one shift-add (MUL*) or restoring-subtract (DIV*/REM*) step per cycle. Go to DONE after XLEN steps.
  - DONE: apply sign correction and select the result: low or high half of the 2*XLEN product, quotient, or remainder. If !stall, load the EX/MEM register and go to IDLE. If stall, stay in DONE.
- Division special cases override the iterative result:
  - Divisor 0: quotient = all ones (signed and unsigned); remainder = dividend.
  - Signed DIV of most-negative by -1: quotient = most-negative; remainder = 0.
- o_execute_busy = (IDLE & issue) | BUSY. It is low in DONE, so upstream advances on the same edge that the result is written.
- EX/MEM register update, in priority order:
  1. Flush: load a bubble (inst 0x00000013; all controls, insn_vld, data and PC = 0; ctrl = i_execute_ctrl). The FSM returns to IDLE, aborting any operation.
  2. Stall: hold all outputs.
  3. Issue or BUSY: load a bubble (ctrl = 0).
  4. DONE: load the M result into alu_data, with the instruction's metadata taken from the held inputs; rs2_data = fwd_b; br flags = 0.
  5. Otherwise: normal load.

## Timing
- Reset (asynchronous assert, synchronous deassert expected):
  - All registered outputs = 0; inst = 0x00000013.
  - FSM = IDLE; busy = 0.
- ALU ops: 1-cycle latency to the EX/MEM outputs.
- M ops:
  - Issue at cycle t.
  - BUSY for cycles t+1..t+XLEN.
  - DONE at t+XLEN+1; result visible at t+XLEN+2 (no stall).
  - busy is high for XLEN+1 cycles.
- A flush at any cycle, including the DONE cycle, takes precedence over the write.
- A stall in DONE extends DONE until release.
- Reset mid-operation discards the operation.
- Arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). Signed results are negated in two's complement.

## Test plan
- ADD with fwd_sel_a=2, bypass source 2 = 0x10, rs2=0x5 -> o_execute_alu_data = 0x15 one cycle later; o_execute_busy stays 0.
- MULH 0x80000000 × 0x80000000 (XLEN=32) -> busy high for 33 cycles; o_execute_alu_data = 0x40000000 at t+34; bubbles emitted in between.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. DIVU 7/0 -> 0xFFFFFFFF. REMU 7/0 -> 7.
- Flush at BUSY cycle 10 of a DIVU -> bubble at the outputs, FSM in IDLE, busy = 0 next cycle. A following ADD completes normally.
- Stall held for 3 cycles across DONE of MUL 6×7 -> outputs hold; 42 appears on the edge after stall release, exactly once.
- Async reset pulse mid-MUL while the clock is stopped -> outputs go immediately to the reset values (inst 0x13, busy 0).
